// File: rtl/sp_ff_pkg.sv
// Shared types for the single-port flip-flop FIFO.
// Port operation encoding used for the registered port trace.
package sp_ff_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_RD,
    OP_WR
  } port_op_t;

endpackage

// File: rtl/sp_ff_array.sv
// Single-port flip-flop array, one access per cycle.
// Synchronous write; registered read data, zeroed on reset.
module sp_ff_array #(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
) (
  input  logic               clk0,
  input  logic               rst0,
  input  logic               csb0,
  input  logic               web0,
  input  logic [S_INDEX-1:0] addr0,
  input  logic [WIDTH-1:0]   din0,
  output logic [WIDTH-1:0]   dout0
);

  localparam int DEPTH = 1 << S_INDEX;

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk0) begin
    if (rst0) begin
      mem   <= '{default: '0};
      dout0 <= '0;
    end else if (!csb0) begin
      if (!web0) begin
        mem[addr0] <= din0;
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

endmodule

// File: rtl/sp_ff_fifo.sv
// Ready/valid FIFO on a single-port FF array plus a
// 2-entry output skid buffer fed by registered reads.
module sp_ff_fifo
  import sp_ff_pkg::*;
#(
  parameter int S_INDEX = 4,
  parameter int WIDTH   = 1
) (
  input  logic               clk0,
  input  logic               rst0_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [S_INDEX+1:0] count
);

  localparam int DEPTH = 1 << S_INDEX;
  localparam int CW    = S_INDEX + 2;
  localparam int AW    = S_INDEX + 1;
  localparam logic [S_INDEX:0] FULL = AW'(DEPTH);

  logic [S_INDEX-1:0] wr_ptr;
  logic [S_INDEX-1:0] rd_ptr;
  logic [S_INDEX:0]   arr_cnt;
  logic [1:0]         out_cnt;
  logic [1:0]         cnt_n;
  logic [WIDTH-1:0]   slot   [2];
  logic [WIDTH-1:0]   slot_n [2];
  logic               wr_starved;
  port_op_t           op_q;
  port_op_t           op_d;

  logic               rd_pend;
  logic               rd_want;
  logic               wr_go;
  logic               rd_go;
  logic               pop;
  logic               arr_full;

  logic               csb0;
  logic               web0;
  logic [S_INDEX-1:0] addr0;
  logic [WIDTH-1:0]   din0;
  logic [WIDTH-1:0]   dout0;

  // A read issued last cycle is exactly a registered OP_RD.
  assign rd_pend   = (op_q == OP_RD);
  assign arr_full  = (arr_cnt == FULL);
  assign rd_want   = (arr_cnt != '0) &&
                     ((3'(out_cnt) + 3'(rd_pend)) < 3'd2);
  assign in_ready  = !arr_full && (!rd_want || wr_starved);
  assign wr_go     = in_valid && in_ready;
  assign rd_go     = rd_want && !wr_go;
  assign out_valid = (out_cnt != 2'd0);
  assign pop       = out_valid && out_ready;
  assign out_data  = slot[0];
  assign count     = CW'(arr_cnt) + CW'(rd_pend) + CW'(out_cnt);

  assign csb0  = 1'b0;
  assign web0  = !wr_go;
  assign addr0 = wr_go ? wr_ptr : rd_ptr;
  assign din0  = in_data;

  always_comb begin
    op_d = OP_IDLE;
    unique case (1'b1)
      wr_go:   op_d = OP_WR;
      rd_go:   op_d = OP_RD;
      default: op_d = OP_IDLE;
    endcase
  end

  // Shift on pop first, then land returning read data.
  always_comb begin
    slot_n = slot;
    cnt_n  = out_cnt;
    if (pop) begin
      if (out_cnt == 2'd2) begin
        slot_n[0] = slot[1];
      end
      cnt_n = out_cnt - 2'd1;
    end
    if (rd_pend) begin
      slot_n[cnt_n[0]] = dout0;
      cnt_n = cnt_n + 2'd1;
    end
  end

  always_ff @(posedge clk0) begin
    if (!rst0_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      arr_cnt    <= '0;
      out_cnt    <= '0;
      slot       <= '{default: '0};
      wr_starved <= 1'b0;
      op_q       <= OP_IDLE;
    end else begin
      if (wr_go) begin
        wr_ptr  <= wr_ptr + 1'b1;
        arr_cnt <= arr_cnt + 1'b1;
      end else if (rd_go) begin
        rd_ptr  <= rd_ptr + 1'b1;
        arr_cnt <= arr_cnt - 1'b1;
      end
      slot       <= slot_n;
      out_cnt    <= cnt_n;
      wr_starved <= in_valid && !in_ready && !arr_full;
      op_q       <= op_d;
    end
  end

  sp_ff_array #(
    .S_INDEX (S_INDEX),
    .WIDTH   (WIDTH)
  ) u_array (
    .clk0  (clk0),
    .rst0  (!rst0_n),
    .csb0  (csb0),
    .web0  (web0),
    .addr0 (addr0),
    .din0  (din0),
    .dout0 (dout0)
  );

endmodule

// File: tb/tb_sp_ff_fifo.sv
// Self-checking bench for sp_ff_fifo: vector table,
// corner sequences and a queue scoreboard.
module tb_sp_ff_fifo;

  localparam int SI = 2;
  localparam int W  = 8;
  localparam int D  = 1 << SI;

  logic          clk0 = 1'b0;
  logic          rst0_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [SI+1:0] count;

  always #5 clk0 = ~clk0;

  sp_ff_fifo #(
    .S_INDEX (SI),
    .WIDTH   (W)
  ) dut (
    .clk0      (clk0),
    .rst0_n    (rst0_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  int checks = 0;
  int errors = 0;
  int n_pop  = 0;

  logic [W-1:0] q[$];

  logic          s_ir;
  logic          s_ov;
  logic [W-1:0]  s_od;
  logic [SI+1:0] s_cnt;

  typedef struct {
    logic         rn;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    bit           chk;
    logic         ir;
    logic         ov;
    logic [W-1:0] od;
    logic [3:0]   cnt;
  } vec_t;

  vec_t tv [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  // Drive one cycle, sample away from the edge, return after it.
  task automatic cyc(input logic rn, input logic iv,
                     input logic [W-1:0] d,
                     input logic ordy);
    rst0_n    = rn;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(negedge clk0);
    s_ir  = in_ready;
    s_ov  = out_valid;
    s_od  = out_data;
    s_cnt = count;
    @(posedge clk0);
    #1;
  endtask

  // Reference: occupancy is accepted minus popped, order is FIFO.
  always @(negedge clk0) begin
    if (!rst0_n) begin
      q.delete();
    end else begin
      chk("sb_count", 32'(count), 32'(q.size()));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("sb_pop_empty", 32'(1), 32'(0));
        end else begin
          chk("sb_order", 32'(out_data), 32'(q[0]));
          void'(q.pop_front());
          n_pop++;
        end
      end
      if (in_valid && in_ready) q.push_back(in_data);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int k;
    int wt;
    int max_wt;
    int base;
    int pushed;
    logic [W-1:0] d;

    tv[0] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0,
              1'b1, 1'b0, 8'h00, 4'd0};
    tv[1] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b1,
              1'b1, 1'b0, 8'h00, 4'd0};
    tv[2] = '{1'b1, 1'b1, 8'hA5, 1'b0, 1'b1,
              1'b1, 1'b0, 8'h00, 4'd0};
    tv[3] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,
              1'b0, 1'b0, 8'h00, 4'd1};
    tv[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,
              1'b1, 1'b0, 8'h00, 4'd1};
    tv[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,
              1'b1, 1'b1, 8'hA5, 4'd1};
    tv[6] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1,
              1'b1, 1'b1, 8'hA5, 4'd1};
    tv[7] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1,
              1'b1, 1'b0, 8'hA5, 4'd0};

    for (int i = 0; i < 8; i++) begin
      cyc(tv[i].rn, tv[i].iv, tv[i].d, tv[i].ordy);
      if (tv[i].chk) begin
        chk($sformatf("vec%0d_in_ready", i), 32'(s_ir), 32'(tv[i].ir));
        chk($sformatf("vec%0d_out_valid", i), 32'(s_ov), 32'(tv[i].ov));
        chk($sformatf("vec%0d_out_data", i), 32'(s_od), 32'(tv[i].od));
        chk($sformatf("vec%0d_count", i), 32'(s_cnt), 32'(tv[i].cnt));
      end
    end

    // Fill: seven offered, six fit (DEPTH + 2).
    acc = 0;
    for (int w = 1; w <= 7; w++) begin
      for (int t = 0; t < 10; t++) begin
        cyc(1'b1, 1'b1, W'(w), 1'b0);
        if (s_ir) begin
          acc++;
          break;
        end
      end
    end
    chk("fill_accepted", 32'(acc), 32'(D + 2));
    chk("fill_in_ready", 32'(s_ir), 32'(0));
    chk("fill_count", 32'(s_cnt), 32'(D + 2));
    k = 1;
    for (int t = 0; t < 40 && k <= 6; t++) begin
      cyc(1'b1, 1'b0, '0, 1'b1);
      if (s_ov) begin
        chk($sformatf("drain_%0d", k), 32'(s_od), 32'(k));
        k++;
      end
    end
    chk("drain_done", 32'(k), 32'(7));

    // Contention: both sides always willing.
    wt = 0;
    max_wt = 0;
    base = n_pop;
    d = W'($urandom);
    for (int t = 0; t < 200; t++) begin
      cyc(1'b1, 1'b1, d, 1'b1);
      if (s_ir) begin
        wt = 0;
        d = W'($urandom);
      end else if (s_cnt < (SI + 2)'(D)) begin
        wt++;
        if (wt > max_wt) max_wt = wt;
      end else begin
        wt = 0;
      end
    end
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, 1'b0, '0, 1'b1);
      if (s_cnt == '0) break;
    end
    chk("cont_max_wait_le2", 32'(max_wt <= 2), 32'(1));
    chk("cont_empty", 32'(s_cnt), 32'(0));
    chk("cont_progress", 32'((n_pop - base) > 50), 32'(1));

    // Wrap: 3x depth with random backpressure.
    base = n_pop;
    pushed = 0;
    d = W'($urandom);
    for (int t = 0; t < 300 && pushed < 3 * D; t++) begin
      cyc(1'b1, 1'b1, d, 1'($urandom_range(0, 1)));
      if (s_ir) begin
        pushed++;
        d = W'($urandom);
      end
    end
    for (int t = 0; t < 40; t++) begin
      cyc(1'b1, 1'b0, '0, 1'b1);
      if (s_cnt == '0) break;
    end
    chk("wrap_pushed", 32'(pushed), 32'(3 * D));
    chk("wrap_popped", 32'(n_pop - base), 32'(3 * D));

    // Reset with data queued and a read in flight.
    pushed = 0;
    for (int t = 0; t < 20 && pushed < 3; t++) begin
      cyc(1'b1, 1'b1, W'(8'h11 * (pushed + 1)), 1'b0);
      if (s_ir) pushed++;
    end
    cyc(1'b1, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 8'h3C, 1'b0);
    chk("rst_mid_count", 32'(s_cnt), 32'(0));
    chk("rst_mid_out_valid", 32'(s_ov), 32'(0));
    chk("rst_mid_in_ready", 32'(s_ir), 32'(1));
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_p1_out_valid", 32'(s_ov), 32'(0));
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_p2_out_valid", 32'(s_ov), 32'(0));
    cyc(1'b1, 1'b0, '0, 1'b1);
    chk("rst_p3_out_valid", 32'(s_ov), 32'(1));
    chk("rst_p3_out_data", 32'(s_od), 32'(8'h3C));
    chk("rst_p3_count", 32'(s_cnt), 32'(1));
    cyc(1'b1, 1'b0, '0, 1'b0);
    chk("rst_p4_count", 32'(s_cnt), 32'(0));
    chk("rst_p4_out_valid", 32'(s_ov), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
